tl_grant_finisher: RTL and testbench
====================================

TL_GRANT_FINISHER -- requirements
Module: tl_grant_finisher

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high, ports named clk and reset.
REQ-002 Parameters SHALL be: DATA_W, default 64, grant data width; CXID_W, default 2, client_xact_id width; MXID_W, default 4, manager_xact_id width; BEATS, default 8, beats per data block (power of two, at least 2); FIN_DEPTH, default 4, finish queue depth (power of two, at least 2).
REQ-003 Ports (name  direction  width  meaning):
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- gin_valid  in  1  grant from manager valid.
- gin_ready  out  1  grant from manager accepted.
- gin_bits_addr_beat, client_xact_id, manager_xact_id, is_builtin_type, g_type, data, client_id  in  log2(BEATS)/CXID_W/MXID_W/1/4/DATA_W/1  grant fields.
- gout_valid  out  1  grant to client valid.
- gout_ready  in  1  client accepts grant.
- gout_bits_*  out  as gin_bits_*  forwarded grant fields.
- finish_valid  out  1  finish message valid.
- finish_ready  in  1  manager accepts finish.
- finish_bits_manager_xact_id  out  MXID_W  xact id being finished.
- pend_cnt  out  log2(FIN_DEPTH)+1  finishes queued.

Function
REQ-004 gout_bits_* SHALL equal gin_bits_* combinationally; gout_valid = gin_valid & ~stall; gin_ready = gout_ready & ~stall.
REQ-005 A grant beat handshake SHALL occur when gin_valid & gin_ready.
REQ-006 A grant SHALL be multi-beat iff (is_builtin_type & g_type==GNT_GET_DATA_BLOCK) or (~is_builtin_type & g_type==GNT_CACHE_DATA); otherwise it is single-beat.
REQ-007 A grant SHALL need a finish unless is_builtin_type & g_type==GNT_VOLUNTARY_ACK.
REQ-008 A beat counter SHALL increment on each multi-beat handshake and wrap to 0 after beat BEATS-1; a beat is last when single-beat or counter==BEATS-1.
REQ-009 stall SHALL be 1 when the current beat is last, needs a finish, and the queue is full; no same-cycle bypass from finish_ready to stall.
REQ-010 On a last-beat handshake needing a finish, manager_xact_id SHALL be pushed into the FIFO; finish_valid rises the next cycle at earliest.
REQ-011 finish_valid SHALL equal queue non-empty; a pop occurs on finish_valid & finish_ready, strictly in FIFO order.
REQ-012 Simultaneous push and pop SHALL both take effect; pend_cnt is unchanged.
REQ-013 pend_cnt SHALL equal queue occupancy (0..FIN_DEPTH) and be registered.
REQ-014 Pointers SHALL wrap modulo FIN_DEPTH; full/empty derive from pend_cnt.

Reset
REQ-015 While reset is high: beat counter=0, queue empty, pend_cnt=0, finish_valid=0, gout_valid=0, gin_ready=0; finish_bits content is don't-care.
REQ-016 Reset mid-burst or with queued finishes SHALL discard all state with no partial recovery.

Configuration
REQ-017 With TL_GRANT_FINISHER_CHECK_EN defined: adds output err (1 bit, sticky until reset), set the cycle after a multi-beat handshake whose addr_beat differs from the beat counter, or after a finish_ready-high pop attempt while empty; without it: no err port or check logic.

Structure
REQ-018 Package tl_pkg SHALL hold G_TYPE_W=4, GNT_VOLUNTARY_ACK=0, GNT_GET_DATA_BLOCK=4, GNT_CACHE_DATA=1, and a grant-fields struct typedef.
REQ-019 The finish queue SHALL be the sub-module tl_fifo (parameters WIDTH, DEPTH).

Verification
REQ-020 Single builtin GNT_VOLUNTARY_ACK, mxid=5 -> forwarded same cycle, no finish, pend_cnt stays 0.
REQ-021 GNT_GET_DATA_BLOCK of 8 beats, mxid=3, finish_ready=1 -> 8 forwarded beats, one finish with id 3 the cycle after beat 7, pend_cnt 1 then 0.
REQ-022 Five finish-needing single-beat grants, finish_ready=0, FIN_DEPTH=4 -> pend_cnt=4, fifth grant stalled (gin_ready=0); finish_ready=1 for one cycle -> fifth accepted next cycle.
REQ-023 Ids 1,2,3 pushed, with push and pop in one cycle at pend_cnt=2 -> pend_cnt stays 2, finishes emerge 1,2,3.
REQ-024 reset asserted after beat 3 of a burst with 2 finishes queued -> next cycle pend_cnt=0, finish_valid=0; new burst starts at beat 0.
REQ-025 CHECK_EN: beat 2 arrives with addr_beat=5 -> err=1 the next cycle and held until reset.

Source files
------------

// File: rtl/tl_pkg.sv
// Shared grant encodings, field struct and type-decoding helpers for the grant finisher.
// Optional checker macro used by the top: TL_GRANT_FINISHER_CHECK_EN.
package tl_pkg;

    localparam int G_TYPE_W = 4;

    localparam logic [G_TYPE_W-1:0] GNT_VOLUNTARY_ACK  = 4'd0;
    localparam logic [G_TYPE_W-1:0] GNT_CACHE_DATA     = 4'd1;
    localparam logic [G_TYPE_W-1:0] GNT_GET_DATA_BLOCK = 4'd4;

    // Grant fields at the default widths (8 beats, 2-bit cxid, 4-bit mxid, 64-bit data).
    typedef struct packed {
        logic [2:0]          addr_beat;
        logic [1:0]          client_xact_id;
        logic [3:0]          manager_xact_id;
        logic                is_builtin_type;
        logic [G_TYPE_W-1:0] g_type;
        logic [63:0]         data;
        logic                client_id;
    } grant_t;

    function automatic logic is_multi_beat(input logic builtin, input logic [G_TYPE_W-1:0] g_type);
        return (builtin && g_type == GNT_GET_DATA_BLOCK) || (!builtin && g_type == GNT_CACHE_DATA);
    endfunction

    function automatic logic needs_finish(input logic builtin, input logic [G_TYPE_W-1:0] g_type);
        return !(builtin && g_type == GNT_VOLUNTARY_ACK);
    endfunction

endpackage

// File: rtl/tl_grant_finisher_if.sv
// Grant-in / grant-out / finish handshake bundle for tl_grant_finisher.
// The slave modport is the finisher's view; master is the surrounding fabric.
interface tl_grant_finisher_if #(
    parameter int DATA_W    = 64,
    parameter int CXID_W    = 2,
    parameter int MXID_W    = 4,
    parameter int BEATS     = 8,
    parameter int FIN_DEPTH = 4
) ();
    import tl_pkg::*;

    localparam int BEAT_W = $clog2(BEATS);
    localparam int CNT_W  = $clog2(FIN_DEPTH) + 1;

    logic                gin_valid;
    logic                gin_ready;
    logic [BEAT_W-1:0]   gin_bits_addr_beat;
    logic [CXID_W-1:0]   gin_bits_client_xact_id;
    logic [MXID_W-1:0]   gin_bits_manager_xact_id;
    logic                gin_bits_is_builtin_type;
    logic [G_TYPE_W-1:0] gin_bits_g_type;
    logic [DATA_W-1:0]   gin_bits_data;
    logic                gin_bits_client_id;

    logic                gout_valid;
    logic                gout_ready;
    logic [BEAT_W-1:0]   gout_bits_addr_beat;
    logic [CXID_W-1:0]   gout_bits_client_xact_id;
    logic [MXID_W-1:0]   gout_bits_manager_xact_id;
    logic                gout_bits_is_builtin_type;
    logic [G_TYPE_W-1:0] gout_bits_g_type;
    logic [DATA_W-1:0]   gout_bits_data;
    logic                gout_bits_client_id;

    logic                finish_valid;
    logic                finish_ready;
    logic [MXID_W-1:0]   finish_bits_manager_xact_id;
    logic [CNT_W-1:0]    pend_cnt;

    modport slave (
        input  gin_valid, gin_bits_addr_beat, gin_bits_client_xact_id, gin_bits_manager_xact_id,
               gin_bits_is_builtin_type, gin_bits_g_type, gin_bits_data, gin_bits_client_id,
               gout_ready, finish_ready,
        output gin_ready, gout_valid, gout_bits_addr_beat, gout_bits_client_xact_id,
               gout_bits_manager_xact_id, gout_bits_is_builtin_type, gout_bits_g_type,
               gout_bits_data, gout_bits_client_id, finish_valid, finish_bits_manager_xact_id,
               pend_cnt
    );

    modport master (
        output gin_valid, gin_bits_addr_beat, gin_bits_client_xact_id, gin_bits_manager_xact_id,
               gin_bits_is_builtin_type, gin_bits_g_type, gin_bits_data, gin_bits_client_id,
               gout_ready, finish_ready,
        input  gin_ready, gout_valid, gout_bits_addr_beat, gout_bits_client_xact_id,
               gout_bits_manager_xact_id, gout_bits_is_builtin_type, gout_bits_g_type,
               gout_bits_data, gout_bits_client_id, finish_valid, finish_bits_manager_xact_id,
               pend_cnt
    );

endinterface

// File: rtl/tl_fifo.sv
// Circular FIFO with a registered occupancy count; full/empty are decoded from the count.
module tl_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples its pre-edge inputs, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; entries are only read once the
    // reset-cleared count marks them valid, so a reset here would only add fan-out.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/tl_grant_finisher.sv
// Forwards manager grants to the client and queues a finish per completed grant.
// Define TL_GRANT_FINISHER_CHECK_EN to add the sticky protocol-error output err.
module tl_grant_finisher
    import tl_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int CXID_W    = 2,
    parameter int MXID_W    = 4,
    parameter int BEATS     = 8,
    parameter int FIN_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    tl_grant_finisher_if.slave io
`ifdef TL_GRANT_FINISHER_CHECK_EN
    ,
    output logic               err
`endif
);
    localparam int                BEAT_W    = $clog2(BEATS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    // Views at the declared widths, so a mis-parameterised interface shows up as a width error.
    logic [DATA_W-1:0] data_fwd;
    logic [CXID_W-1:0] cxid_fwd;
    logic [MXID_W-1:0] mxid_fwd;

    logic [BEAT_W-1:0] beat_cnt;
    logic              multi;
    logic              need_fin;
    logic              last_beat;
    logic              stall;
    logic              hs;
    logic              push;
    logic              pop;
    logic              q_full;
    logic              q_empty;

    assign data_fwd = io.gin_bits_data;
    assign cxid_fwd = io.gin_bits_client_xact_id;
    assign mxid_fwd = io.gin_bits_manager_xact_id;

    assign io.gout_bits_addr_beat       = io.gin_bits_addr_beat;
    assign io.gout_bits_client_xact_id  = cxid_fwd;
    assign io.gout_bits_manager_xact_id = mxid_fwd;
    assign io.gout_bits_is_builtin_type = io.gin_bits_is_builtin_type;
    assign io.gout_bits_g_type          = io.gin_bits_g_type;
    assign io.gout_bits_data            = data_fwd;
    assign io.gout_bits_client_id       = io.gin_bits_client_id;

    assign multi     = is_multi_beat(io.gin_bits_is_builtin_type, io.gin_bits_g_type);
    assign need_fin  = needs_finish(io.gin_bits_is_builtin_type, io.gin_bits_g_type);
    assign last_beat = ~multi | (beat_cnt == LAST_BEAT);

    // Only a finish-producing last beat must wait for room; earlier beats flow freely.
    assign stall = last_beat & need_fin & q_full;

    assign io.gout_valid = io.gin_valid & ~stall & ~reset;
    assign io.gin_ready  = io.gout_ready & ~stall & ~reset;

    assign hs   = io.gin_valid & io.gin_ready;
    assign push = hs & last_beat & need_fin;
    assign pop  = io.finish_valid & io.finish_ready;

    assign io.finish_valid = ~q_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt <= '0;
        end else if (hs && multi) begin
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

    tl_fifo #(
        .WIDTH (MXID_W),
        .DEPTH (FIN_DEPTH)
    ) u_fin_q (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (mxid_fwd),
        .pop       (pop),
        .pop_data  (io.finish_bits_manager_xact_id),
        .count     (io.pend_cnt),
        .full      (q_full),
        .empty     (q_empty)
    );

`ifdef TL_GRANT_FINISHER_CHECK_EN
    logic beat_mismatch;
    logic empty_pop;

    assign beat_mismatch = hs & multi & (io.gin_bits_addr_beat != beat_cnt);
    assign empty_pop     = io.finish_ready & q_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if (beat_mismatch || empty_pop) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_tl_grant_finisher.sv
// Directed bench for tl_grant_finisher: forwarding, finish queueing, back-pressure and reset.
// Finish ids are predicted into a scoreboard queue when a grant is driven and checked on pop.
module tb_tl_grant_finisher;
    import tl_pkg::*;

    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    logic [3:0] sb [$];

`ifdef TL_GRANT_FINISHER_CHECK_EN
    logic err;
`endif

    tl_grant_finisher_if #(.DATA_W(64), .CXID_W(2), .MXID_W(4), .BEATS(8), .FIN_DEPTH(4)) io ();

    tl_grant_finisher #(
        .DATA_W    (64),
        .CXID_W    (2),
        .MXID_W    (4),
        .BEATS     (8),
        .FIN_DEPTH (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .io    (io.slave)
`ifdef TL_GRANT_FINISHER_CHECK_EN
        ,
        .err   (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic grant_t mk(input logic [2:0] beat, input logic builtin,
                                  input logic [3:0] gt, input logic [3:0] mxid);
        grant_t g;
        g.addr_beat       = beat;
        g.client_xact_id  = mxid[1:0];
        g.manager_xact_id = mxid;
        g.is_builtin_type = builtin;
        g.g_type          = gt;
        g.data            = 64'hF00D_0000_0000_0000 ^ {56'd0, mxid, 1'b0, beat};
        g.client_id       = mxid[0];
        return g;
    endfunction

    // Drives one grant beat for a cycle and checks the combinational response.
    task automatic send(input grant_t g, input logic fin_rdy, input logic exp_rdy,
                        input logic exp_push, input string tag);
        @(negedge clk);
        io.gin_valid                = 1'b1;
        io.gin_bits_addr_beat       = g.addr_beat;
        io.gin_bits_client_xact_id  = g.client_xact_id;
        io.gin_bits_manager_xact_id = g.manager_xact_id;
        io.gin_bits_is_builtin_type = g.is_builtin_type;
        io.gin_bits_g_type          = g.g_type;
        io.gin_bits_data            = g.data;
        io.gin_bits_client_id       = g.client_id;
        io.finish_ready             = fin_rdy;
        #2;
        check({tag, ".gin_ready"}, 64'(io.gin_ready), 64'(exp_rdy));
        check({tag, ".gout_valid"}, 64'(io.gout_valid), 64'(exp_rdy));
        check({tag, ".gout_mxid"}, 64'(io.gout_bits_manager_xact_id), 64'(g.manager_xact_id));
        check({tag, ".gout_data"}, io.gout_bits_data, g.data);
        if (exp_rdy && exp_push) sb.push_back(g.manager_xact_id);
    endtask

    task automatic idle(input logic fin_rdy);
        @(negedge clk);
        io.gin_valid    = 1'b0;
        io.finish_ready = fin_rdy;
        #2;
    endtask

    // Finish monitor: samples mid-cycle, before the edge that performs the pop.
    always begin
        @(negedge clk);
        #3;
        if (!reset && io.finish_valid === 1'b1 && io.finish_ready === 1'b1) begin
            total++;
            assert (sb.size() != 0) else begin
                bad++;
                $error("FAIL fin_extra observed=%0h expected=none", io.finish_bits_manager_xact_id);
            end
            if (sb.size() != 0) check("fin_id", 64'(io.finish_bits_manager_xact_id), 64'(sb.pop_front()));
        end
    end

    initial begin
        reset = 1'b1;
        io.gin_valid                = 1'b1;
        io.gin_bits_addr_beat       = '0;
        io.gin_bits_client_xact_id  = '0;
        io.gin_bits_manager_xact_id = 4'd1;
        io.gin_bits_is_builtin_type = 1'b1;
        io.gin_bits_g_type          = 4'd3;
        io.gin_bits_data            = '0;
        io.gin_bits_client_id       = 1'b0;
        io.gout_ready               = 1'b1;
        io.finish_ready             = 1'b0;

        // Reset state, with a valid grant presented that must not be accepted.
        @(negedge clk);
        @(negedge clk);
        #2;
        check("rst.gin_ready", 64'(io.gin_ready), 64'd0);
        check("rst.gout_valid", 64'(io.gout_valid), 64'd0);
        check("rst.pend_cnt", 64'(io.pend_cnt), 64'd0);
        check("rst.finish_valid", 64'(io.finish_valid), 64'd0);
        @(negedge clk);
        reset        = 1'b0;
        io.gin_valid = 1'b0;

        // Voluntary ack: forwarded, never finished.
        send(mk(3'd0, 1'b1, GNT_VOLUNTARY_ACK, 4'd5), 1'b1, 1'b1, 1'b0, "vack");
        idle(1'b1);
        check("vack.pend_cnt", 64'(io.pend_cnt), 64'd0);
        check("vack.finish_valid", 64'(io.finish_valid), 64'd0);

        // Eight-beat data block: one finish after the last beat.
        for (int i = 0; i < 8; i++)
            send(mk(3'(i), 1'b1, GNT_GET_DATA_BLOCK, 4'd3), 1'b1, 1'b1, (i == 7), "blk");
        check("blk.no_early_finish", 64'(io.finish_valid), 64'd0);
        idle(1'b1);
        check("blk.finish_valid", 64'(io.finish_valid), 64'd1);
        check("blk.pend_cnt1", 64'(io.pend_cnt), 64'd1);
        idle(1'b1);
        check("blk.pend_cnt0", 64'(io.pend_cnt), 64'd0);
        check("blk.finish_done", 64'(io.finish_valid), 64'd0);

        // Fill the finish queue, then stall the fifth grant.
        for (int i = 0; i < 4; i++)
            send(mk(3'd0, 1'b1, 4'd3, 4'(8 + i)), 1'b0, 1'b1, 1'b1, "fill");
        send(mk(3'd0, 1'b1, 4'd3, 4'd12), 1'b0, 1'b0, 1'b1, "full_stall");
        check("full.pend_cnt", 64'(io.pend_cnt), 64'd4);
        send(mk(3'd0, 1'b1, 4'd3, 4'd12), 1'b1, 1'b0, 1'b1, "full_nobypass");
        send(mk(3'd0, 1'b1, 4'd3, 4'd12), 1'b0, 1'b1, 1'b1, "full_accept");
        check("full.pend_after_pop", 64'(io.pend_cnt), 64'd3);
        for (int i = 0; i < 4; i++) idle(1'b1);
        idle(1'b0);
        check("full.drained", 64'(io.pend_cnt), 64'd0);

        // Push and pop in the same cycle at occupancy 2.
        send(mk(3'd0, 1'b0, 4'd2, 4'd1), 1'b0, 1'b1, 1'b1, "pp1");
        send(mk(3'd0, 1'b0, 4'd2, 4'd2), 1'b0, 1'b1, 1'b1, "pp2");
        send(mk(3'd0, 1'b0, 4'd2, 4'd3), 1'b1, 1'b1, 1'b1, "pp3");
        check("pp.pend_before", 64'(io.pend_cnt), 64'd2);
        idle(1'b0);
        check("pp.pend_after", 64'(io.pend_cnt), 64'd2);
        idle(1'b1);
        idle(1'b1);
        idle(1'b0);
        check("pp.drained", 64'(io.pend_cnt), 64'd0);

        // Reset mid-burst with two finishes queued.
        send(mk(3'd0, 1'b1, 4'd3, 4'd6), 1'b0, 1'b1, 1'b1, "mr6");
        send(mk(3'd0, 1'b1, 4'd3, 4'd7), 1'b0, 1'b1, 1'b1, "mr7");
        for (int i = 0; i < 4; i++)
            send(mk(3'(i), 1'b1, GNT_GET_DATA_BLOCK, 4'd4), 1'b0, 1'b1, 1'b0, "mrb");
        idle(1'b0);
        check("mr.pend_before", 64'(io.pend_cnt), 64'd2);
        @(negedge clk);
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        #2;
        check("mr.pend_cnt", 64'(io.pend_cnt), 64'd0);
        check("mr.finish_valid", 64'(io.finish_valid), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++)
            send(mk(3'(i), 1'b1, GNT_GET_DATA_BLOCK, 4'd13), 1'b0, 1'b1, 1'b0, "nb_lo");
        idle(1'b0);
        check("nb.pend_mid", 64'(io.pend_cnt), 64'd0);
        for (int i = 4; i < 8; i++)
            send(mk(3'(i), 1'b1, GNT_GET_DATA_BLOCK, 4'd13), 1'b0, 1'b1, (i == 7), "nb_hi");
        idle(1'b0);
        check("nb.pend_end", 64'(io.pend_cnt), 64'd1);
        idle(1'b1);
        idle(1'b0);
        check("nb.drained", 64'(io.pend_cnt), 64'd0);

`ifdef TL_GRANT_FINISHER_CHECK_EN
        // Out-of-order beat index sets the sticky error.
        @(negedge clk);
        reset           = 1'b1;
        io.gin_valid    = 1'b0;
        io.finish_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #2;
        check("err.clear", 64'(err), 64'd0);
        send(mk(3'd0, 1'b1, GNT_GET_DATA_BLOCK, 4'd2), 1'b0, 1'b1, 1'b0, "eb0");
        send(mk(3'd1, 1'b1, GNT_GET_DATA_BLOCK, 4'd2), 1'b0, 1'b1, 1'b0, "eb1");
        check("err.before", 64'(err), 64'd0);
        send(mk(3'd5, 1'b1, GNT_GET_DATA_BLOCK, 4'd2), 1'b0, 1'b1, 1'b0, "eb2");
        idle(1'b0);
        check("err.set", 64'(err), 64'd1);
        idle(1'b0);
        idle(1'b0);
        check("err.sticky", 64'(err), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #2;
        check("err.reset", 64'(err), 64'd0);
        reset = 1'b0;
`endif

        idle(1'b0);
        check("sb.drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
